// File: rtl/vscale_htif_pcr_bridge_pkg.sv
// rtl/vscale_htif_pcr_bridge_pkg.sv - shared HTIF constants, bridge state encodings and helpers
// Optional feature macro: VSCALE_HTIF_TOHOST_CLR_EN (adds the CLEAR state).
package vscale_htif_pcr_bridge_pkg;

  localparam int HTIF_PCR_WIDTH = 64;
  localparam int WAIT_CNT_WIDTH = 8;

  // Taken from the CSR address map.
  localparam logic [11:0] CSR_ADDR_TO_HOST   = 12'h780;
  localparam logic [11:0] CSR_ADDR_FROM_HOST = 12'h781;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_CLEAR  = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

  function automatic logic [WAIT_CNT_WIDTH-1:0] wait_cnt_sat_inc(
    input logic [WAIT_CNT_WIDTH-1:0] cnt
  );
    return (&cnt) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/vscale_htif_pcr_bridge_if.sv
// rtl/vscale_htif_pcr_bridge_if.sv - HTIF PCR channel plus shared CSR host port bundle
// slave = bridge view, master = host/CSR-file view.
interface vscale_htif_pcr_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int XPR_LEN    = 32,
  parameter int PCR_WIDTH  = 64
);

  logic                  htif_pcr_req_valid;
  logic                  htif_pcr_req_ready;
  logic                  htif_pcr_req_rw;
  logic [ADDR_WIDTH-1:0] htif_pcr_req_addr;
  logic [PCR_WIDTH-1:0]  htif_pcr_req_data;
  logic                  htif_pcr_resp_valid;
  logic                  htif_pcr_resp_ready;
  logic [PCR_WIDTH-1:0]  htif_pcr_resp_data;
  logic                  core_csr_busy;
  logic                  host_csr_en;
  logic                  host_csr_wen;
  logic [ADDR_WIDTH-1:0] host_csr_addr;
  logic [XPR_LEN-1:0]    host_csr_wdata;
  logic [XPR_LEN-1:0]    host_csr_rdata;
  logic                  host_stall_core;

  modport slave (
    input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    input  htif_pcr_resp_ready, core_csr_busy, host_csr_rdata,
    output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
    output host_csr_en, host_csr_wen, host_csr_addr, host_csr_wdata, host_stall_core
  );

  modport master (
    output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    output htif_pcr_resp_ready, core_csr_busy, host_csr_rdata,
    input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data,
    input  host_csr_en, host_csr_wen, host_csr_addr, host_csr_wdata, host_stall_core
  );

endinterface

// File: rtl/vscale_htif_pcr_bridge.sv
// rtl/vscale_htif_pcr_bridge.sv - HTIF PCR request/response front end of the CSR file
// VSCALE_HTIF_TOHOST_CLR_EN: a host read of to_host is followed by a clearing write of 0.
module vscale_htif_pcr_bridge
  import vscale_htif_pcr_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int XPR_LEN     = 32,
  parameter int PCR_WIDTH   = HTIF_PCR_WIDTH,
  parameter int STALL_LIMIT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  vscale_htif_pcr_bridge_if.slave       htif_if
);

  localparam logic [WAIT_CNT_WIDTH-1:0] STALL_THRESH = WAIT_CNT_WIDTH'(STALL_LIMIT - 1);
  localparam logic [ADDR_WIDTH-1:0]     TO_HOST_ADDR = ADDR_WIDTH'(CSR_ADDR_TO_HOST);

  bridge_state_e              state_q;
  logic                       rw_q;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic [XPR_LEN-1:0]         wdata_q;
  logic [PCR_WIDTH-1:0]       resp_q;
  logic                       req_ready_q;
  logic                       resp_valid_q;
  logic                       stall_q;
  logic [WAIT_CNT_WIDTH-1:0]  wait_cnt_q;
  logic [WAIT_CNT_WIDTH-1:0]  wait_cnt_d;

  logic                       in_access;
  logic                       in_clear;
  logic                       port_free;
  logic                       clear_after_access;
  logic [PCR_WIDTH-XPR_LEN-1:0] unused_req_data_hi;

  assign unused_req_data_hi = htif_if.htif_pcr_req_data[PCR_WIDTH-1:XPR_LEN];

  assign in_access  = (state_q == ST_ACCESS);
  assign port_free  = !htif_if.core_csr_busy;
  assign wait_cnt_d = wait_cnt_sat_inc(wait_cnt_q);

`ifdef VSCALE_HTIF_TOHOST_CLR_EN
  assign in_clear           = (state_q == ST_CLEAR);
  assign clear_after_access = !rw_q && (addr_q == TO_HOST_ADDR);
`else
  assign in_clear           = 1'b0;
  assign clear_after_access = 1'b0;
`endif

  // The port grant must react to core_csr_busy in the same cycle, so it stays combinational.
  assign htif_if.host_csr_en    = (in_access || in_clear) && port_free;
  assign htif_if.host_csr_wen   = htif_if.host_csr_en && (in_clear || rw_q);
  assign htif_if.host_csr_addr  = addr_q;
  assign htif_if.host_csr_wdata = in_clear ? '0 : wdata_q;

  assign htif_if.htif_pcr_req_ready  = req_ready_q;
  assign htif_if.htif_pcr_resp_valid = resp_valid_q;
  assign htif_if.htif_pcr_resp_data  = resp_q;
  assign htif_if.host_stall_core     = stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_q       <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      stall_q      <= 1'b0;
      wait_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (htif_if.htif_pcr_req_valid && req_ready_q) begin
            rw_q        <= htif_if.htif_pcr_req_rw;
            addr_q      <= htif_if.htif_pcr_req_addr;
            wdata_q     <= htif_if.htif_pcr_req_data[XPR_LEN-1:0];
            req_ready_q <= 1'b0;
            state_q     <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (port_free) begin
            // Pre-access value: a write returns what it overwrote.
            resp_q     <= PCR_WIDTH'(htif_if.host_csr_rdata);
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
            if (clear_after_access) begin
              state_q <= ST_CLEAR;
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d >= STALL_THRESH) stall_q <= 1'b1;
          end
        end

`ifdef VSCALE_HTIF_TOHOST_CLR_EN
        ST_CLEAR: begin
          if (port_free) begin
            wait_cnt_q   <= '0;
            stall_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d >= STALL_THRESH) stall_q <= 1'b1;
          end
        end
`endif

        ST_RESP: begin
          if (htif_if.htif_pcr_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        default: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          stall_q      <= 1'b0;
          wait_cnt_q   <= '0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_htif_pcr_bridge.sv
// tb/tb_vscale_htif_pcr_bridge.sv - directed self-checking bench for vscale_htif_pcr_bridge
module tb_vscale_htif_pcr_bridge;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] to_host   = 32'h0;
  logic [31:0] from_host = 32'h0;
  int          wr_cnt    = 0;

  always #5 clk = ~clk;

  vscale_htif_pcr_bridge_if #(.ADDR_WIDTH(12), .XPR_LEN(32), .PCR_WIDTH(64)) bus ();

  vscale_htif_pcr_bridge #(
    .ADDR_WIDTH(12), .XPR_LEN(32), .PCR_WIDTH(64), .STALL_LIMIT(16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .htif_if(bus)
  );

  // CSR file stand-in: combinational read, write on the clock edge.
  always_comb begin
    bus.host_csr_rdata = 32'h0;
    if (bus.host_csr_addr == 12'h780) bus.host_csr_rdata = to_host;
    else if (bus.host_csr_addr == 12'h781) bus.host_csr_rdata = from_host;
  end

  always @(posedge clk) begin
    if (bus.host_csr_en && bus.host_csr_wen) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.host_csr_addr == 12'h780) to_host <= bus.host_csr_wdata;
      if (bus.host_csr_addr == 12'h781) from_host <= bus.host_csr_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input string tag, input logic rw, input logic [11:0] a,
                      input logic [63:0] d, input logic [63:0] exp);
    int n;
    n = 0;
    cyc();
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_rw    = rw;
    bus.htif_pcr_req_addr  = a;
    bus.htif_pcr_req_data  = d;
    @(negedge clk);
    chk({tag, "_req_ready"}, bus.htif_pcr_req_ready, 1);
    cyc();
    bus.htif_pcr_req_valid = 1'b0;
    @(negedge clk);
    while (!bus.htif_pcr_resp_valid && n < 50) begin
      cyc();
      @(negedge clk);
      n++;
    end
    chk({tag, "_resp_timeout"}, (n < 50), 1);
    chk({tag, "_resp_data"}, bus.htif_pcr_resp_data, exp);
    bus.htif_pcr_resp_ready = 1'b1;
    cyc();
    bus.htif_pcr_resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_resp_done"}, bus.htif_pcr_resp_valid, 0);
  endtask

  initial begin
    int wr_before;
    reset                   = 1'b1;
    bus.htif_pcr_req_valid  = 1'b0;
    bus.htif_pcr_req_rw     = 1'b0;
    bus.htif_pcr_req_addr   = 12'h0;
    bus.htif_pcr_req_data   = 64'h0;
    bus.htif_pcr_resp_ready = 1'b0;
    bus.core_csr_busy       = 1'b0;
    from_host               = 32'h1234;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_req_ready", bus.htif_pcr_req_ready, 1);
    chk("rst_resp_valid", bus.htif_pcr_resp_valid, 0);
    chk("rst_resp_data", bus.htif_pcr_resp_data, 0);
    chk("rst_csr_en", bus.host_csr_en, 0);
    chk("rst_stall", bus.host_stall_core, 0);
    chk("rst_csr_addr", bus.host_csr_addr, 0);
    cyc();
    reset = 1'b0;

    // Read from_host with the core idle: access at N+1, response at N+2.
    cyc();
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_rw    = 1'b0;
    bus.htif_pcr_req_addr  = 12'h781;
    @(negedge clk);
    chk("rd_accept_ready", bus.htif_pcr_req_ready, 1);
    chk("rd_idle_en", bus.host_csr_en, 0);
    cyc();
    bus.htif_pcr_req_valid = 1'b0;
    @(negedge clk);
    chk("rd_access_en", bus.host_csr_en, 1);
    chk("rd_access_wen", bus.host_csr_wen, 0);
    chk("rd_access_addr", bus.host_csr_addr, 12'h781);
    chk("rd_access_resp_valid", bus.htif_pcr_resp_valid, 0);
    chk("rd_access_req_ready", bus.htif_pcr_req_ready, 0);
    cyc();
    @(negedge clk);
    chk("rd_resp_valid", bus.htif_pcr_resp_valid, 1);
    chk("rd_resp_data", bus.htif_pcr_resp_data, 64'h0000_0000_0000_1234);
    chk("rd_resp_en", bus.host_csr_en, 0);
    bus.htif_pcr_resp_ready = 1'b1;
    cyc();
    bus.htif_pcr_resp_ready = 1'b0;
    @(negedge clk);
    chk("rd_done_valid", bus.htif_pcr_resp_valid, 0);
    chk("rd_done_ready", bus.htif_pcr_req_ready, 1);

    // Write to_host: upper data bits dropped, old value returned.
    cyc();
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_rw    = 1'b1;
    bus.htif_pcr_req_addr  = 12'h780;
    bus.htif_pcr_req_data  = 64'hFFFF_FFFF_0000_00AB;
    @(negedge clk);
    cyc();
    bus.htif_pcr_req_valid = 1'b0;
    @(negedge clk);
    chk("wr_en", bus.host_csr_en, 1);
    chk("wr_wen", bus.host_csr_wen, 1);
    chk("wr_wdata", bus.host_csr_wdata, 32'h0000_00AB);
    cyc();
    @(negedge clk);
    chk("wr_resp_valid", bus.htif_pcr_resp_valid, 1);
    chk("wr_resp_old", bus.htif_pcr_resp_data, 64'h0);
    bus.htif_pcr_resp_ready = 1'b1;
    cyc();
    bus.htif_pcr_resp_ready = 1'b0;
    xact("rd_after_wr", 1'b0, 12'h780, 64'h0, 64'hAB);
    xact("rd_undef", 1'b0, 12'h123, 64'h0, 64'h0);

`ifdef VSCALE_HTIF_TOHOST_CLR_EN
    xact("wr_tohost5", 1'b1, 12'h780, 64'h5, 64'h0);
    wr_before = wr_cnt;
    xact("rd_tohost_clr", 1'b0, 12'h780, 64'h0, 64'h5);
    chk("clr_write_count", 32'(wr_cnt - wr_before), 1);
    chk("clr_tohost_zero", to_host, 0);
    xact("rd_tohost_after", 1'b0, 12'h780, 64'h0, 64'h0);
`else
    wr_before = wr_cnt;
    xact("rd_tohost_again", 1'b0, 12'h780, 64'h0, 64'hAB);
    chk("nondestructive_writes", 32'(wr_cnt - wr_before), 0);
`endif

    // Core holds the port for 20 cycles; stall follows the wait counter reaching 15.
    cyc();
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_rw    = 1'b0;
    bus.htif_pcr_req_addr  = 12'h781;
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      cyc();
      bus.htif_pcr_req_valid = 1'b0;
      bus.core_csr_busy      = 1'b1;
      @(negedge clk);
      chk($sformatf("busy_en_%0d", i), bus.host_csr_en, 0);
      if (i == 15 || i == 16 || i == 20)
        chk($sformatf("busy_stall_%0d", i), bus.host_stall_core, (i >= 16) ? 1 : 0);
    end
    cyc();
    bus.core_csr_busy = 1'b0;
    @(negedge clk);
    chk("busy_free_en", bus.host_csr_en, 1);
    chk("busy_free_stall_held", bus.host_stall_core, 1);
    cyc();
    @(negedge clk);
    chk("busy_resp_valid", bus.htif_pcr_resp_valid, 1);
    chk("busy_stall_clear", bus.host_stall_core, 0);
    chk("busy_resp_data", bus.htif_pcr_resp_data, 64'h1234);
    bus.htif_pcr_resp_ready = 1'b1;
    cyc();
    bus.htif_pcr_resp_ready = 1'b0;

    // Response back-pressure: held stable, no new request accepted meanwhile.
    from_host = 32'h55AA;
    cyc();
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_addr  = 12'h781;
    @(negedge clk);
    cyc();
    @(negedge clk);
    cyc();
    from_host = 32'h7777;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", i), bus.htif_pcr_resp_valid, 1);
      chk($sformatf("bp_data_%0d", i), bus.htif_pcr_resp_data, 64'h55AA);
      chk($sformatf("bp_req_ready_%0d", i), bus.htif_pcr_req_ready, 0);
      chk($sformatf("bp_en_%0d", i), bus.host_csr_en, 0);
      cyc();
    end
    bus.htif_pcr_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_req_ready", bus.htif_pcr_req_ready, 0);
    cyc();
    bus.htif_pcr_resp_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", bus.htif_pcr_resp_valid, 0);
    chk("bp_after_req_ready", bus.htif_pcr_req_ready, 1);
    cyc();
    bus.htif_pcr_req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_en", bus.host_csr_en, 1);
    cyc();
    @(negedge clk);
    chk("bp_next_data", bus.htif_pcr_resp_data, 64'h7777);
    bus.htif_pcr_resp_ready = 1'b1;
    cyc();
    bus.htif_pcr_resp_ready = 1'b0;

    // Reset while a write waits in ACCESS: request discarded, nothing written.
    cyc();
    bus.htif_pcr_req_valid = 1'b1;
    bus.htif_pcr_req_rw    = 1'b1;
    bus.htif_pcr_req_addr  = 12'h781;
    bus.htif_pcr_req_data  = 64'h99;
    @(negedge clk);
    for (int i = 1; i <= 17; i++) begin
      cyc();
      bus.htif_pcr_req_valid = 1'b0;
      bus.core_csr_busy      = 1'b1;
    end
    @(negedge clk);
    chk("rst_mid_stall_before", bus.host_stall_core, 1);
    cyc();
    reset = 1'b1;
    cyc();
    reset             = 1'b0;
    bus.core_csr_busy = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_ready", bus.htif_pcr_req_ready, 1);
    chk("rst_mid_resp_valid", bus.htif_pcr_resp_valid, 0);
    chk("rst_mid_stall", bus.host_stall_core, 0);
    chk("rst_mid_en", bus.host_csr_en, 0);
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_mid_no_resp", bus.htif_pcr_resp_valid, 0);
    chk("rst_mid_no_write", from_host, 32'h7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
